// File: rtl/mem_port_arbiter_if.sv
// Shared-memory port bundle: instruction-fetch requester, data requester and the single memory port.
// The arbiter is the slave of both requesters and drives the memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch vs. data) onto one single-ported synchronous memory.
// Data has priority; a saturating starve counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e            state_q;
  logic              owner_q;   // 0 = fetch, 1 = data
  logic              op_we_q;   // current access is a store
  logic [CntW-1:0]   starve_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic any_req;
  logic starve_sat;
  logic fetch_win;
  logic store_win;

  assign any_req    = bus.if_req | bus.d_req;
  assign starve_sat = (starve_q == CntW'(STARVE_MAX));
  assign fetch_win  = bus.if_req & (~bus.d_req | starve_sat);
  assign store_win  = ~fetch_win & bus.d_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      op_we_q     <= 1'b0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StResp: begin
          if (any_req) begin
            state_q     <= StIssue;
            owner_q     <= ~fetch_win;
            op_we_q     <= store_win;
            mem_en_q    <= 1'b1;
            mem_we_q    <= store_win;
            mem_addr_q  <= fetch_win ? bus.if_addr : bus.d_addr;
            mem_wdata_q <= store_win ? bus.d_wdata : '0;
            // Count data wins that made a live fetch wait; any other grant clears.
            if (fetch_win || !bus.if_req) begin
              starve_q <= '0;
            end else if (!starve_sat) begin
              starve_q <= starve_q + CntW'(1);
            end
          end else begin
            state_q     <= StIdle;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
        end
        StIssue: begin
          state_q  <= StResp;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic resp;
  assign resp = (state_q == StResp);

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.if_gnt   = mem_en_q & ~owner_q;
  assign bus.d_gnt    = mem_en_q & owner_q;
  assign bus.if_valid = resp & ~owner_q;
  assign bus.d_valid  = resp & owner_q;
  assign bus.if_rdata = (resp && !owner_q) ? bus.mem_rdata : '0;
  assign bus.d_rdata  = (resp && owner_q && !op_we_q) ? bus.mem_rdata : '0;

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table plus starvation and
// reset-during-issue sequences against a small synchronous memory model.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic mem_load;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  // Word-addressed memory, index = addr[9:2]; read data valid the cycle after the enabled edge.
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | i;
      mem[4]  <= 32'h0000_0013;
      mem[64] <= 32'hCAFE_0100;
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[9:2]] : '0;
    end
  end

  typedef struct packed {
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
  } outs_t;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    outs_t       exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic outs_t o_idle();
    outs_t o;
    o = '0;
    return o;
  endfunction

  function automatic outs_t o_fgnt(input logic [15:0] a);
    outs_t o;
    o = '0; o.if_gnt = 1'b1; o.mem_en = 1'b1; o.mem_addr = a; o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_fval(input logic [15:0] a, input logic [31:0] rd);
    outs_t o;
    o = '0; o.if_valid = 1'b1; o.if_rdata = rd; o.mem_addr = a; o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_dgnt(input logic [15:0] a, input logic we, input logic [31:0] wd);
    outs_t o;
    o = '0; o.d_gnt = 1'b1; o.mem_en = 1'b1; o.mem_we = we; o.mem_addr = a;
    o.mem_wdata = wd; o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_dval(input logic [15:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd);
    outs_t o;
    o = '0; o.d_valid = 1'b1; o.d_rdata = rd; o.mem_addr = a; o.mem_wdata = wd; o.busy = 1'b1;
    return o;
  endfunction

  function automatic vec_t mk(input logic r, input logic ir, input logic [15:0] ia,
                              input logic dr, input logic dw, input logic [15:0] da,
                              input logic [31:0] dd, input outs_t e);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dd; v.exp = e;
    return v;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("gnt(i,d)=%b%b val(i,d)=%b%b ird=%h drd=%h en=%b we=%b addr=%h wd=%h busy=%b",
                     o.if_gnt, o.d_gnt, o.if_valid, o.d_valid, o.if_rdata, o.d_rdata,
                     o.mem_en, o.mem_we, o.mem_addr, o.mem_wdata, o.busy);
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.if_gnt = bus.if_gnt;   o.if_valid = bus.if_valid; o.if_rdata  = bus.if_rdata;
    o.d_gnt  = bus.d_gnt;    o.d_valid  = bus.d_valid;  o.d_rdata   = bus.d_rdata;
    o.mem_en = bus.mem_en;   o.mem_we   = bus.mem_we;   o.mem_addr  = bus.mem_addr;
    o.mem_wdata = bus.mem_wdata; o.busy = busy;
    return o;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; bus.if_req = v.if_req; bus.if_addr = v.if_addr; bus.d_req = v.d_req;
    bus.d_we = v.d_we; bus.d_addr = v.d_addr; bus.d_wdata = v.d_wdata;
  endtask

  task automatic apply(input vec_t v, input string tag);
    outs_t act;
    drive(v);
    @(posedge clk);
    #1;
    act = sample();
    n_vec++;
    if (act !== v.exp) begin
      n_err++;
      $display("FAIL %s: got {%s} want {%s}", tag, fmt(act), fmt(v.exp));
    end
  endtask

  vec_t  tbl[$];
  string order;
  int    k;
  byte   g;

  initial begin
    mem_load = 1'b1;
    drive(mk(1, 0, 0, 0, 0, 0, 0, o_idle()));
    @(posedge clk);
    #1;
    mem_load = 1'b0;

    // reset, fetch-only, simultaneous, store, reload, re-serve
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, o_idle()));
    tbl.push_back(mk(1, 1, 16'h0010, 1, 0, 16'h0100, 0, o_idle()));
    tbl.push_back(mk(0, 1, 16'h0010, 0, 0, 16'h0000, 0, o_fgnt(16'h0010)));
    tbl.push_back(mk(0, 1, 16'h0010, 0, 0, 16'h0000, 0, o_fval(16'h0010, 32'h0000_0013)));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, o_idle()));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0100, 0, o_dgnt(16'h0100, 0, 0)));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0100, 0, o_dval(16'h0100, 0, 32'hCAFE_0100)));
    tbl.push_back(mk(0, 1, 16'h0020, 0, 0, 16'h0000, 0, o_fgnt(16'h0020)));
    tbl.push_back(mk(0, 1, 16'h0020, 0, 0, 16'h0000, 0, o_fval(16'h0020, 32'h1000_0008)));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, o_idle()));
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'h0204, 32'hDEAD_BEEF,
                     o_dgnt(16'h0204, 1, 32'hDEAD_BEEF)));
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'h0204, 32'hDEAD_BEEF,
                     o_dval(16'h0204, 32'hDEAD_BEEF, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, o_idle()));
    tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0204, 0, o_dgnt(16'h0204, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0204, 0, o_dval(16'h0204, 0, 32'hDEAD_BEEF)));
    tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0204, 0, o_dgnt(16'h0204, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0204, 0, o_dval(16'h0204, 0, 32'hDEAD_BEEF)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, o_idle()));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset while a fetch sits in ISSUE: abandoned, no valid afterwards.
    apply(mk(0, 1, 16'h0010, 0, 0, 0, 0, o_fgnt(16'h0010)), "rst_issue_gnt");
    apply(mk(1, 1, 16'h0010, 0, 0, 0, 0, o_idle()), "rst_issue_clear");
    apply(mk(0, 0, 16'h0000, 0, 0, 0, 0, o_idle()), "rst_issue_no_valid");

    // Reset while a store is in ISSUE: memory still commits it.
    apply(mk(0, 0, 0, 1, 1, 16'h0208, 32'h1234_5678, o_dgnt(16'h0208, 1, 32'h1234_5678)),
          "rst_store_gnt");
    apply(mk(1, 0, 0, 1, 1, 16'h0208, 32'h1234_5678, o_idle()), "rst_store_clear");
    apply(mk(0, 0, 0, 0, 0, 16'h0000, 0, o_idle()), "rst_store_no_valid");
    apply(mk(0, 0, 0, 1, 0, 16'h0208, 0, o_dgnt(16'h0208, 0, 0)), "rst_store_load_gnt");
    apply(mk(0, 0, 0, 1, 0, 16'h0208, 0, o_dval(16'h0208, 0, 32'h1234_5678)),
          "rst_store_committed");
    apply(mk(0, 0, 0, 0, 0, 16'h0000, 0, o_idle()), "rst_store_idle");

    // Starvation: both held high, grant order D,D,D,F then counter restarts from 0.
    apply(mk(1, 0, 0, 0, 0, 0, 0, o_idle()), "starve_reset");
    drive(mk(0, 1, 16'h0030, 1, 0, 16'h0040, 0, o_idle()));
    order = "DDDFDDDF";
    k = 0;
    for (int c = 0; c < 24 && k < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.if_gnt || bus.d_gnt) begin
        g = bus.d_gnt ? "D" : "F";
        n_vec++;
        if ((bus.if_gnt && bus.d_gnt) || g != order[k] ||
            bus.mem_addr != (bus.d_gnt ? 16'h0040 : 16'h0030)) begin
          n_err++;
          $display("FAIL starve_grant%0d: got %s gnt(i,d)=%b%b addr=%h want %s", k,
                   string'(g), bus.if_gnt, bus.d_gnt, bus.mem_addr, string'(order[k]));
        end
        k++;
      end
    end
    if (k < 8) begin
      n_vec++;
      n_err++;
      $display("FAIL starve_timeout: got %0d grants want 8", k);
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, o_idle()));
    @(posedge clk);
    @(posedge clk);
    #1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, o_idle()), "starve_drain_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte address width (matches PC width).
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, max consecutive data grants while fetch waits.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 if_req  in  1  fetch read request, held with if_addr until if_valid.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 if_gnt  out  1  fetch access issued this cycle.
REQ-010 if_valid  out  1  fetch read data valid this cycle.
REQ-011 if_rdata  out  DATA_W  fetch read data.
REQ-012 d_req  in  1  data request (load/store), held with d_we/d_addr/d_wdata until d_valid.
REQ-013 d_we  in  1  1 = store, 0 = load.
REQ-014 d_addr  in  ADDR_W  data address.
REQ-015 d_wdata  in  DATA_W  store data.
REQ-016 d_gnt  out  1  data access issued this cycle.
REQ-017 d_valid  out  1  data access complete this cycle.
REQ-018 d_rdata  out  DATA_W  load data.
REQ-019 mem_en  out  1  memory port enable.
REQ-020 mem_we  out  1  memory write enable.
REQ-021 mem_addr  out  ADDR_W  memory address.
REQ-022 mem_wdata  out  DATA_W  memory write data.
REQ-023 mem_rdata  in  DATA_W  memory read data, valid the cycle after an enabled read edge.
REQ-024 busy  out  1  arbiter not in IDLE.

Function
REQ-025 SHALL implement FSM states IDLE, ISSUE, RESP plus registered owner bit (0 = fetch, 1 = data).
REQ-026 IDLE or RESP, at edge with any req high: SHALL pick winner, register mem_en=1, mem_addr, mem_we (data store only), mem_wdata (store data, else 0), go ISSUE.
REQ-027 IDLE or RESP, no req: SHALL go/stay IDLE with mem_en=mem_we=0, mem_addr=mem_wdata=0.
REQ-028 ISSUE SHALL always go RESP next edge, clearing mem_en and mem_we.
REQ-029 if_gnt/d_gnt SHALL equal mem_en qualified by owner (ISSUE cycle only).
REQ-030 if_valid/d_valid SHALL be high exactly in RESP, qualified by owner; stores also pulse d_valid.
REQ-031 if_rdata/d_rdata SHALL equal mem_rdata when the respective valid is high, else 0; d_rdata = 0 for stores.
REQ-032 Latency: req sampled at edge E -> gnt in cycle after E -> valid one cycle later; peak throughput one access per 2 cycles.
REQ-033 Request sampled in RESP state SHALL be treated as new; requester being completed SHALL drop req by the edge ending RESP, else it is re-served.
REQ-034 Priority: data wins when both req high, unless starve counter == STARVE_MAX, then fetch wins.
REQ-035 Starve counter (width clog2(STARVE_MAX+1)) SHALL increment on data grant with if_req high, clear on fetch grant or data grant with if_req low, saturate at STARVE_MAX.
REQ-036 Only one requester SHALL be granted per access; the loser keeps waiting with no signal change.
REQ-037 busy SHALL be high in ISSUE and RESP.
REQ-038 Requester changing address/data while waiting SHALL be sampled at grant edge; no error detection.

Reset
REQ-039 rst high at an edge SHALL force IDLE, owner=0, starve counter=0, all outputs 0, regardless of state.
REQ-040 Access in ISSUE when rst asserts SHALL be abandoned with no valid pulse; a store whose mem_we was high at that same edge is committed by memory and not undone.
REQ-041 rst SHALL dominate any simultaneous request.

Verification
REQ-042 Fetch only: if_req=1, if_addr=0x0010, mem returns 0x00000013 -> if_gnt cycle 1, mem_addr=0x0010, if_valid with if_rdata=0x00000013 cycle 2.
REQ-043 Simultaneous: if_req=d_req=1, d_we=0, d_addr=0x0100 -> d_gnt first, mem_we=0; fetch granted after d_valid once d_req drops.
REQ-044 Store: d_we=1, d_addr=0x0204, d_wdata=0xDEADBEEF -> mem_we=1 one cycle with those values, d_valid next cycle, d_rdata=0.
REQ-045 Starvation: d_req and if_req held high, STARVE_MAX=3 -> grant order D,D,D,F,D, counter 0 after F.
REQ-046 Reset in ISSUE: rst during fetch ISSUE -> no if_valid, all outputs 0 next cycle, busy=0.
